// File: rtl/token_run_length.sv
// Run-length extractor for a serial token stream: counts runs of '1' tokens and
// queues each completed run length in a small FIFO with sticky overflow flags.
module token_run_length #(
  parameter int LEN_W   = 9,
  parameter int DEPTH   = 4,
  parameter int MAX_RUN = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             len_valid,
  input  logic             len_ready,
  output logic [LEN_W-1:0] len,
  output logic             run_overflow,
  output logic             fifo_overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [LEN_W-1:0] CNT_MAX    = '1;
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE    = OCC_W'(1);

  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic             run_ovf_reg, run_ovf_next;
  logic             fifo_ovf_reg, fifo_ovf_next;

  logic [LEN_W-1:0] mem [DEPTH];

  logic push, pop, full, wr_en, drop, run_limit_hit;

  always_comb begin
    push          = !a && (cnt_reg != '0);
    pop           = (occ_reg != '0) && len_ready;
    full          = (occ_reg == OCC_FULL);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    wr_en         = push && (!full || pop);
    drop          = push && full && !pop;
    run_limit_hit = a && (32'(cnt_reg) >= 32'(MAX_RUN));
  end

  always_comb begin
    cnt_next      = cnt_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    occ_next      = occ_reg;
    run_ovf_next  = run_ovf_reg;
    fifo_ovf_next = fifo_ovf_reg;

    if (a) begin
      if (cnt_reg != CNT_MAX) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else begin
      cnt_next = '0;
    end

    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    case ({wr_en, pop})
      2'b10:   occ_next = occ_reg + OCC_ONE;
      2'b01:   occ_next = occ_reg - OCC_ONE;
      default: occ_next = occ_reg;
    endcase

    if (run_limit_hit) begin
      run_ovf_next = 1'b1;
    end
    if (drop) begin
      fifo_ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      run_ovf_reg  <= 1'b0;
      fifo_ovf_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      occ_reg      <= occ_next;
      run_ovf_reg  <= run_ovf_next;
      fifo_ovf_reg <= fifo_ovf_next;
    end
  end

  // Storage carries no reset; stale contents are hidden by the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= cnt_reg;
    end
  end

  always_comb begin
    len_valid     = (occ_reg != '0);
    len           = len_valid ? mem[rd_ptr_reg] : '0;
    run_overflow  = run_ovf_reg;
    fifo_overflow = fifo_ovf_reg;
  end

endmodule

// File: tb/tb_token_run_length.sv
// Directed bench for token_run_length: a reference model keeps a queue of the
// run lengths the FIFO should hold and every cycle compares the head and flags.
module tb_token_run_length;

  localparam int LEN_W   = 9;
  localparam int DEPTH   = 4;
  localparam int MAX_RUN = 400;
  localparam int SAT     = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a = 1'b0;
  logic             len_ready = 1'b0;
  logic             len_valid;
  logic [LEN_W-1:0] len;
  logic             run_overflow;
  logic             fifo_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  int exp_q[$];
  int m_run      = 0;
  bit m_run_ovf  = 1'b0;
  bit m_fifo_ovf = 1'b0;

  token_run_length #(.LEN_W(LEN_W), .DEPTH(DEPTH), .MAX_RUN(MAX_RUN)) dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .len_valid    (len_valid),
    .len_ready    (len_ready),
    .len          (len),
    .run_overflow (run_overflow),
    .fifo_overflow(fifo_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int head;
    head = (exp_q.size() != 0) ? exp_q[0] : 0;
    chk({tag, ".len_valid"}, 32'(len_valid), 32'(exp_q.size() != 0));
    chk({tag, ".len"}, 32'(len), 32'(head));
    chk({tag, ".run_overflow"}, 32'(run_overflow), 32'(m_run_ovf));
    chk({tag, ".fifo_overflow"}, 32'(fifo_overflow), 32'(m_fifo_ovf));
  endtask

  // One clock cycle: drive inputs mid-cycle, check state, then advance the model
  // through the coming rising edge.
  task automatic cyc(input string tag, input bit av, input bit rv);
    bit full, popped;
    int popped_len;
    @(negedge clk);
    a         = av;
    len_ready = rv;
    #1;
    check_outputs(tag);
    full   = (exp_q.size() == DEPTH);
    popped = (exp_q.size() != 0) && rv;
    if (popped) begin
      popped_len = exp_q.pop_front();
      $display("cycle %s: popped len=%0d", tag, popped_len);
    end
    if (av) begin
      if (m_run >= MAX_RUN) m_run_ovf = 1'b1;
      if (m_run < SAT) m_run++;
    end else if (m_run > 0) begin
      if (!full || popped) exp_q.push_back(m_run);
      else m_fifo_ovf = 1'b1;
      m_run = 0;
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_run      = 0;
    m_run_ovf  = 1'b0;
    m_fifo_ovf = 1'b0;
    check_outputs(tag);
    $display("reset %s: outputs checked while rst asserted", tag);
    @(posedge clk);
    @(negedge clk);
    a   = 1'b0;
    rst = 1'b0;
  endtask

  task automatic ones(input string tag, input int n, input bit rv);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, rv);
  endtask

  task automatic idle(input string tag, input int n, input bit rv);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, rv);
  endtask

  initial begin
    #1;
    check_outputs("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic run extraction
    begin
      bit pat[8] = '{0, 1, 1, 0, 1, 1, 1, 0};
      foreach (pat[i]) cyc("extract", pat[i], 1'b1);
      idle("extract_tail", 3, 1'b1);
    end

    // FIFO full: fifth run is dropped, four length-1 entries drain in order
    for (int i = 0; i < 5; i++) begin
      cyc("fill", 1'b1, 1'b0);
      cyc("fill", 1'b0, 1'b0);
    end
    idle("full_hold", 3, 1'b0);
    idle("drain", 6, 1'b1);

    // Push and pop on the same edge while full
    apply_reset("reset_before_pushpop");
    for (int r = 1; r <= 4; r++) begin
      ones("load", r, 1'b0);
      cyc("load", 1'b0, 1'b0);
    end
    ones("fifth_run", 5, 1'b0);
    cyc("fifth_end", 1'b0, 1'b1);
    idle("pushpop_drain", 6, 1'b1);

    // Run limit: 401 ones, reported with its true length
    ones("limit", MAX_RUN + 1, 1'b1);
    cyc("limit_end", 1'b0, 1'b1);
    idle("limit_idle", 50, 1'b1);

    // Saturation at 2^LEN_W-1
    apply_reset("reset_before_sat");
    ones("sat", 600, 1'b1);
    cyc("sat_end", 1'b0, 1'b1);
    idle("sat_idle", 3, 1'b1);

    // Asynchronous reset mid-run with two entries queued
    apply_reset("reset_before_midrun");
    ones("q", 2, 1'b0);
    cyc("q", 1'b0, 1'b0);
    ones("q", 3, 1'b0);
    cyc("q", 1'b0, 1'b0);
    ones("midrun", 10, 1'b0);
    apply_reset("reset_midrun");
    cyc("after_reset", 1'b1, 1'b1);
    cyc("after_reset", 1'b0, 1'b1);
    idle("after_reset_idle", 4, 1'b1);

    // Pseudo-random mix of tokens and back-pressure
    for (int i = 0; i < 300; i++) begin
      cyc("random", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
    end
    idle("random_drain", 8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
